// File: rtl/v_issue_ctrl.sv
// v_issue_ctrl: single-issue sequencer for the vector coprocessor.
// Accepts one decoded instruction at a time, pulses the start of the
// selected functional unit, waits for that unit's done (with a timeout),
// then emits one-cycle writeback strobes for the CSR or register files.
// All outputs come straight from flops; no input reaches an output
// combinationally.

module v_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [2:0] unit_sel,
    input  logic       is_vconfig,
    input  logic [4:0] vd_in,
    input  logic       v_wr_req,
    input  logic       x_wr_req,
    output logic [4:0] unit_start,
    input  logic [4:0] unit_done,
    output logic       csr_wr_en,
    output logic       reg_wr_en,
    output logic [4:0] vd_out,
    output logic       x_reg_wr_en,
    output logic       busy,
    output logic       timeout_err,
    input  logic       err_clr
);

    // Wait-cycle counter sized so TIMEOUT_CYCLES itself is representable.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CFG   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WB    = 3'd4
    } state_t;

    // True when the selector names a real functional unit (1..5).
    function automatic logic is_unit_f(input logic [2:0] sel);
        logic hit;
        case (sel)
            3'd1, 3'd2, 3'd3, 3'd4, 3'd5: hit = 1'b1;
            default:                      hit = 1'b0;
        endcase
        return hit;
    endfunction

    // One-hot start vector for a unit selector; NOP codes map to zero.
    function automatic logic [4:0] onehot_f(input logic [2:0] sel);
        logic [4:0] oh;
        case (sel)
            3'd1:    oh = 5'b00001;
            3'd2:    oh = 5'b00010;
            3'd3:    oh = 5'b00100;
            3'd4:    oh = 5'b01000;
            3'd5:    oh = 5'b10000;
            default: oh = 5'b00000;
        endcase
        return oh;
    endfunction

    // Picks only the done bit belonging to the selected unit.
    function automatic logic done_pick_f(input logic [2:0] sel, input logic [4:0] done);
        logic d;
        case (sel)
            3'd1:    d = done[0];
            3'd2:    d = done[1];
            3'd3:    d = done[2];
            3'd4:    d = done[3];
            3'd5:    d = done[4];
            default: d = 1'b0;
        endcase
        return d;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             timeout_s;
    logic             accept_s;
    logic             done_sel_s;

    logic [2:0]       sel_r;
    logic             cfg_r;
    logic [4:0]       vd_r;
    logic             v_wr_r;
    logic             x_wr_r;

    logic             ready_r;
    logic             busy_r;
    logic [4:0]       start_r;
    logic             csr_wr_r;
    logic             reg_wr_r;
    logic             x_reg_wr_r;
    logic             err_r;

    assign accept_s = instr_valid & (state_r == ST_IDLE);
    // A vconfig never owns a unit, so it can never complete on a done bit.
    assign done_sel_s = ~cfg_r & done_pick_f(sel_r, unit_done);

    // Next-state and counter update for the issue sequence.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (is_vconfig) begin
                        state_nxt_s = ST_CFG;
                    end else if (is_unit_f(unit_sel)) begin
                        state_nxt_s = ST_ISSUE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CFG: begin
                state_nxt_s = ST_IDLE;
            end
            ST_ISSUE: begin
                cnt_nxt_s   = CNT_ZERO;
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                // Done takes priority over the terminal count.
                if (done_sel_s) begin
                    state_nxt_s = ST_WB;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_IDLE;
                    timeout_s   = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_WB: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Capture the instruction fields on accept; held until the next accept.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            sel_r  <= 3'd0;
            cfg_r  <= 1'b0;
            vd_r   <= 5'd0;
            v_wr_r <= 1'b0;
            x_wr_r <= 1'b0;
        end else if (accept_s) begin
            sel_r  <= unit_sel;
            cfg_r  <= is_vconfig;
            vd_r   <= vd_in;
            v_wr_r <= v_wr_req;
            x_wr_r <= x_wr_req;
        end else begin
            sel_r  <= sel_r;
            cfg_r  <= cfg_r;
            vd_r   <= vd_r;
            v_wr_r <= v_wr_r;
            x_wr_r <= x_wr_r;
        end
    end

    // Output flops decoded from the state being entered, so each strobe
    // is high exactly while the controller sits in the matching state.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
            start_r    <= 5'b00000;
            csr_wr_r   <= 1'b0;
            reg_wr_r   <= 1'b0;
            x_reg_wr_r <= 1'b0;
        end else begin
            ready_r    <= (state_nxt_s == ST_IDLE);
            busy_r     <= (state_nxt_s != ST_IDLE);
            // ISSUE is only ever entered from IDLE, using the live selector.
            start_r    <= ((state_r == ST_IDLE) && (state_nxt_s == ST_ISSUE)) ?
                          onehot_f(unit_sel) : 5'b00000;
            csr_wr_r   <= (state_nxt_s == ST_CFG);
            reg_wr_r   <= (state_nxt_s == ST_WB) & v_wr_r;
            x_reg_wr_r <= (state_nxt_s == ST_WB) & x_wr_r;
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end else if (err_clr) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r;
        end
    end

    assign instr_ready = ready_r;
    assign busy        = busy_r;
    assign unit_start  = start_r;
    assign csr_wr_en   = csr_wr_r;
    assign reg_wr_en   = reg_wr_r;
    assign x_reg_wr_en = x_reg_wr_r;
    assign vd_out      = vd_r;
    assign timeout_err = err_r;

endmodule

// File: tb/tb_v_issue_ctrl.sv
// tb_v_issue_ctrl: table-driven bench for v_issue_ctrl (TIMEOUT_CYCLES = 4).
// Each table row gives the inputs for one cycle and the outputs expected
// right after the following rising edge; a few hand sequences follow.

module tb_v_issue_ctrl;

    logic       clk;
    logic       nrst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] unit_sel;
    logic       is_vconfig;
    logic [4:0] vd_in;
    logic       v_wr_req;
    logic       x_wr_req;
    logic [4:0] unit_start;
    logic [4:0] unit_done;
    logic       csr_wr_en;
    logic       reg_wr_en;
    logic [4:0] vd_out;
    logic       x_reg_wr_en;
    logic       busy;
    logic       timeout_err;
    logic       err_clr;

    int n_vec;
    int n_miss;

    typedef struct {
        logic       n;
        logic       v;
        logic [2:0] s;
        logic       c;
        logic [4:0] vd;
        logic       vw;
        logic       xw;
        logic [4:0] dn;
        logic       clr;
        logic       e_rdy;
        logic [4:0] e_start;
        logic       e_csr;
        logic       e_rw;
        logic [4:0] e_vd;
        logic       e_xw;
        logic       e_err;
    } vec_t;

    vec_t vec_q[$];

    v_issue_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .unit_sel    (unit_sel),
        .is_vconfig  (is_vconfig),
        .vd_in       (vd_in),
        .v_wr_req    (v_wr_req),
        .x_wr_req    (x_wr_req),
        .unit_start  (unit_start),
        .unit_done   (unit_done),
        .csr_wr_en   (csr_wr_en),
        .reg_wr_en   (reg_wr_en),
        .vd_out      (vd_out),
        .x_reg_wr_en (x_reg_wr_en),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic n, input logic v, input logic [2:0] s, input logic c,
                       input logic [4:0] vd, input logic vw, input logic xw,
                       input logic [4:0] dn, input logic clr,
                       input logic e_rdy, input logic [4:0] e_start, input logic e_csr,
                       input logic e_rw, input logic [4:0] e_vd, input logic e_xw,
                       input logic e_err);
        vec_t r;
        r.n = n; r.v = v; r.s = s; r.c = c; r.vd = vd; r.vw = vw; r.xw = xw;
        r.dn = dn; r.clr = clr;
        r.e_rdy = e_rdy; r.e_start = e_start; r.e_csr = e_csr; r.e_rw = e_rw;
        r.e_vd = e_vd; r.e_xw = e_xw; r.e_err = e_err;
        vec_q.push_back(r);
    endtask

    task automatic drive(input logic n, input logic v, input logic [2:0] s, input logic c,
                         input logic [4:0] vd, input logic vw, input logic xw,
                         input logic [4:0] dn, input logic clr);
        nrst = n; instr_valid = v; unit_sel = s; is_vconfig = c; vd_in = vd;
        v_wr_req = vw; x_wr_req = xw; unit_done = dn; err_clr = clr;
    endtask

    // Compare every output against an expected set; busy must be !ready.
    task automatic check(input string name, input logic e_rdy, input logic [4:0] e_start,
                         input logic e_csr, input logic e_rw, input logic [4:0] e_vd,
                         input logic e_xw, input logic e_err);
        logic [15:0] act;
        logic [15:0] exp_v;
        act   = {instr_ready, busy, unit_start, csr_wr_en, reg_wr_en, vd_out,
                 x_reg_wr_en, timeout_err};
        exp_v = {e_rdy, ~e_rdy, e_start, e_csr, e_rw, e_vd, e_xw, e_err};
        n_vec++;
        if (act !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got rdy/busy/start/csr/rw/vd/xw/err=%b, expected %b",
                     name, act, exp_v);
        end
    endtask

    initial begin
        int  cyc;
        bit  seen;
        n_vec  = 0;
        n_miss = 0;
        drive(1'b0, 1'b1, 3'd1, 1'b0, 5'd7, 1'b1, 1'b0, 5'b00000, 1'b0);

        //   n     v     sel   cfg   vd     vw    xw    done      clr  | rdy   start     csr   rw    vd     xw    err
        // reset held with valid high: no accept
        add(1'b0, 1'b1, 3'd1, 1'b0, 5'd7,  1'b1, 1'b0, 5'b00000, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0);
        add(1'b0, 1'b1, 3'd1, 1'b0, 5'd7,  1'b1, 1'b0, 5'b00000, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0);
        // VALU vd=7, done at T+5 (also the terminal count): WB at T+6, ready T+7
        add(1'b1, 1'b1, 3'd1, 1'b0, 5'd7,  1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 5'b00001, 1'b0, 1'b0, 5'd7,  1'b0, 1'b0);
        add(1'b1, 1'b1, 3'd2, 1'b0, 5'd31, 1'b1, 1'b1, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'd7,  1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'd7,  1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'd7,  1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'd7,  1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00001, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0);
        add(1'b1, 1'b1, 3'd5, 1'b0, 5'd20, 1'b1, 1'b1, 5'b00000, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 5'd7,  1'b0, 1'b0);
        // VRED x-write with VALU done held: only done[2] completes
        add(1'b1, 1'b1, 3'd3, 1'b0, 5'd9,  1'b0, 1'b1, 5'b00001, 1'b0, 1'b0, 5'b00100, 1'b0, 1'b0, 5'd9,  1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00001, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'd9,  1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00001, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'd9,  1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00101, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'd9,  1'b1, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00001, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 5'd9,  1'b0, 1'b0);
        // vconfig overrides unit_sel; input during CFG ignored
        add(1'b1, 1'b1, 3'd1, 1'b1, 5'd3,  1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 5'd3,  1'b0, 1'b0);
        add(1'b1, 1'b1, 3'd1, 1'b0, 5'd30, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 5'd3,  1'b0, 1'b0);
        // back-to-back NOPs (0, 6, 7): accepted, fields latched, no strobes
        add(1'b1, 1'b1, 3'd0, 1'b0, 5'd4,  1'b1, 1'b0, 5'b00000, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 5'd4,  1'b0, 1'b0);
        add(1'b1, 1'b1, 3'd6, 1'b0, 5'd5,  1'b1, 1'b1, 5'b00000, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 5'd5,  1'b0, 1'b0);
        add(1'b1, 1'b1, 3'd7, 1'b0, 5'd6,  1'b1, 1'b0, 5'b00000, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 5'd6,  1'b0, 1'b0);
        // VSLDU never done: done in ISSUE and foreign dones ignored; timeout at T+6
        add(1'b1, 1'b1, 3'd4, 1'b0, 5'd10, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 5'b01000, 1'b0, 1'b0, 5'd10, 1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b01000, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'd10, 1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b10111, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'd10, 1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'd10, 1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'd10, 1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00000, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 5'd10, 1'b0, 1'b1);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00000, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 5'd10, 1'b0, 1'b1);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00000, 1'b1, 1'b1, 5'b00000, 1'b0, 1'b0, 5'd10, 1'b0, 1'b0);
        // VLSU timeout with err_clr in the same cycle: set wins
        add(1'b1, 1'b1, 3'd5, 1'b0, 5'd2,  1'b1, 1'b1, 5'b00000, 1'b0, 1'b0, 5'b10000, 1'b0, 1'b0, 5'd2,  1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'd2,  1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'd2,  1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'd2,  1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'd2,  1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00000, 1'b1, 1'b1, 5'b00000, 1'b0, 1'b0, 5'd2,  1'b0, 1'b1);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00000, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 5'd2,  1'b0, 1'b1);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00000, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 5'd2,  1'b0, 1'b1);
        // reset mid-WAIT clears error and fields; late done ignored
        add(1'b1, 1'b1, 3'd1, 1'b0, 5'd8,  1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 5'b00001, 1'b0, 1'b0, 5'd8,  1'b0, 1'b1);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 5'd8,  1'b0, 1'b1);
        add(1'b0, 1'b1, 3'd1, 1'b0, 5'd8,  1'b1, 1'b0, 5'b00000, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00001, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b00001, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0);

        for (int i = 0; i < vec_q.size(); i++) begin
            drive(vec_q[i].n, vec_q[i].v, vec_q[i].s, vec_q[i].c, vec_q[i].vd,
                  vec_q[i].vw, vec_q[i].xw, vec_q[i].dn, vec_q[i].clr);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vec_q[i].e_rdy, vec_q[i].e_start, vec_q[i].e_csr,
                  vec_q[i].e_rw, vec_q[i].e_vd, vec_q[i].e_xw, vec_q[i].e_err);
        end

        // Minimum occupancy: VMUL with done held high from the start.
        drive(1'b1, 1'b1, 3'd2, 1'b0, 5'd12, 1'b1, 1'b1, 5'b00010, 1'b0);
        @(posedge clk); #1;
        check("fast_issue", 1'b0, 5'b00010, 1'b0, 1'b0, 5'd12, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'b00010, 1'b0);
        @(posedge clk); #1;
        check("fast_wait", 1'b0, 5'b00000, 1'b0, 1'b0, 5'd12, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("fast_wb", 1'b0, 5'b00000, 1'b0, 1'b1, 5'd12, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 3'd0, 1'b0, 5'd12, 1'b0, 1'b0, 5'b00000, 1'b0);
        @(posedge clk); #1;
        check("fast_ready", 1'b1, 5'b00000, 1'b0, 1'b0, 5'd12, 1'b0, 1'b0);

        // Bounded wait for a VMUL writeback with done pulsed one WAIT cycle.
        drive(1'b1, 1'b1, 3'd2, 1'b0, 5'd13, 1'b1, 1'b0, 5'b00000, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'b00000, 1'b0);
        cyc  = 0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #1;
            cyc++;
            if (reg_wr_en === 1'b1) begin
                seen = 1'b1;
                unit_done = 5'b00000;
            end else if (cyc == 1) begin
                unit_done = 5'b00010;
            end else begin
                unit_done = 5'b00000;
            end
        end
        n_vec++;
        if (!seen || cyc != 2 || vd_out !== 5'd13 || x_reg_wr_en !== 1'b0) begin
            n_miss++;
            $display("FAIL wb_wait: seen=%0d cycles=%0d vd=%0d xw=%b, expected seen=1 cycles=2 vd=13 xw=0",
                     seen, cyc, vd_out, x_reg_wr_en);
        end
        @(posedge clk); #1;
        check("wb_wait_ready", 1'b1, 5'b00000, 1'b0, 1'b0, 5'd13, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
